// File: rtl/display_buffer_writer_pkg.sv
// Shared display definitions: screen geometry, pixel/coordinate types,
// command opcodes and the writer's FSM encoding.
package display_buffer_writer_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W  = 10;
  localparam int PIXEL_W  = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIXEL_W-1:0] pixel_t;

  // Codes 2 and 3 are deliberately unnamed; the engine treats them as NOP.
  typedef enum logic [1:0] {
    OP_FILL    = 2'd0,
    OP_PRESENT = 2'd1
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FILL        = 2'd1,
    ST_WAIT_VBLANK = 2'd2,
    ST_SWAP        = 2'd3
  } state_t;

  function automatic coord_t clamp_coord(input coord_t value, input coord_t limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/display_buffer_writer_if.sv
// Command channel into the display buffer writer: valid/ready handshake
// carrying an opcode, an inclusive rectangle and a fill colour.
interface display_buffer_writer_if;
  import display_buffer_writer_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  cmd_op_t cmd_op;
  coord_t  cmd_x0;
  coord_t  cmd_y0;
  coord_t  cmd_x1;
  coord_t  cmd_y1;
  pixel_t  cmd_color;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_x0,
    output cmd_y0,
    output cmd_x1,
    output cmd_y1,
    output cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_x0,
    input  cmd_y0,
    input  cmd_x1,
    input  cmd_y1,
    input  cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/display_buffer_writer_rect_raster_counter.sv
// Row-major walker over an inclusive rectangle; x/y always name the pixel
// currently being written and hold their value when neither loaded nor advanced.
module rect_raster_counter
  import display_buffer_writer_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  coord_t x0,
  input  coord_t x1,
  input  coord_t y0,
  input  coord_t y1,
  input  logic   advance,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  coord_t x_reg;
  coord_t y_reg;
  coord_t x0_reg;
  coord_t x1_reg;
  coord_t y1_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_reg  <= '0;
      y_reg  <= '0;
      x0_reg <= '0;
      x1_reg <= '0;
      y1_reg <= '0;
    end else if (load) begin
      x_reg  <= x0;
      y_reg  <= y0;
      x0_reg <= x0;
      x1_reg <= x1;
      y1_reg <= y1;
    end else if (advance) begin
      // Row wrap happens in the same cycle as the last column, so no bubble.
      if (x_reg == x1_reg) begin
        x_reg <= x0_reg;
        y_reg <= y_reg + coord_t'(1);
      end else begin
        x_reg <= x_reg + coord_t'(1);
      end
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign last = (x_reg == x1_reg) && (y_reg == y1_reg);

endmodule

// File: rtl/display_buffer_writer.sv
// Back-buffer render engine: rasterises rectangle fills at one pixel per
// cycle and issues a buffer-swap pulse on the next vertical-blank rising edge.
module display_buffer_writer
  import display_buffer_writer_pkg::*;
#(
  parameter int H_ACTIVE = display_buffer_writer_pkg::H_ACTIVE,
  parameter int V_ACTIVE = display_buffer_writer_pkg::V_ACTIVE
) (
  input  logic                   clock,
  input  logic                   reset,
  display_buffer_writer_if.slave cmd,
  input  logic                   vblank,
  output coord_t                 address_b_x,
  output coord_t                 address_b_y,
  output logic                   write_enable_b,
  output pixel_t                 write_data_b,
  output logic                   frame_complete,
  output logic                   busy
);

  localparam coord_t X_MAX = coord_t'(H_ACTIVE - 1);
  localparam coord_t Y_MAX = coord_t'(V_ACTIVE - 1);

  state_t state_reg;
  state_t state_next;
  logic   vblank_q_reg;
  logic   empty_reg;
  logic   empty_next;
  logic   write_enable_reg;
  logic   write_enable_next;
  pixel_t write_data_reg;
  pixel_t write_data_next;
  logic   frame_complete_reg;
  logic   frame_complete_next;

  logic   accept;
  logic   vblank_rise;
  logic   rect_empty;
  logic   raster_load;
  logic   raster_advance;
  logic   raster_last;
  coord_t raster_x;
  coord_t raster_y;
  coord_t x0_clamped;
  coord_t x1_clamped;
  coord_t y0_clamped;
  coord_t y1_clamped;

  assign x0_clamped  = clamp_coord(cmd.cmd_x0, X_MAX);
  assign x1_clamped  = clamp_coord(cmd.cmd_x1, X_MAX);
  assign y0_clamped  = clamp_coord(cmd.cmd_y0, Y_MAX);
  assign y1_clamped  = clamp_coord(cmd.cmd_y1, Y_MAX);
  assign rect_empty  = (x0_clamped > x1_clamped) || (y0_clamped > y1_clamped);

  assign cmd.cmd_ready = (state_reg == ST_IDLE);
  assign accept        = cmd.cmd_valid && (state_reg == ST_IDLE);
  // vblank_q is updated in every state, so a level already high at accept
  // cannot masquerade as a fresh edge.
  assign vblank_rise   = vblank && !vblank_q_reg;

  rect_raster_counter u_raster (
    .clock   (clock),
    .reset   (reset),
    .load    (raster_load),
    .x0      (x0_clamped),
    .x1      (x1_clamped),
    .y0      (y0_clamped),
    .y1      (y1_clamped),
    .advance (raster_advance),
    .x       (raster_x),
    .y       (raster_y),
    .last    (raster_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_FILL:    state_next = ST_FILL;
            OP_PRESENT: state_next = ST_WAIT_VBLANK;
            default:    state_next = ST_IDLE;
          endcase
        end
      end
      ST_FILL: begin
        if (empty_reg || raster_last) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_VBLANK: begin
        if (vblank_rise) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Computes next values of the registered outputs plus raster controls.
  always_comb begin
    raster_load         = 1'b0;
    raster_advance      = 1'b0;
    empty_next          = empty_reg;
    write_enable_next   = 1'b0;
    write_data_next     = write_data_reg;
    frame_complete_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept && (cmd.cmd_op == OP_FILL)) begin
          empty_next      = rect_empty;
          write_data_next = cmd.cmd_color;
          if (!rect_empty) begin
            raster_load       = 1'b1;
            write_enable_next = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (!(empty_reg || raster_last)) begin
          raster_advance    = 1'b1;
          write_enable_next = 1'b1;
        end
      end
      ST_WAIT_VBLANK: begin
        frame_complete_next = vblank_rise;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vblank_q_reg       <= 1'b0;
      empty_reg          <= 1'b0;
      write_enable_reg   <= 1'b0;
      write_data_reg     <= '0;
      frame_complete_reg <= 1'b0;
    end else begin
      vblank_q_reg       <= vblank;
      empty_reg          <= empty_next;
      write_enable_reg   <= write_enable_next;
      write_data_reg     <= write_data_next;
      frame_complete_reg <= frame_complete_next;
    end
  end

  assign address_b_x    = raster_x;
  assign address_b_y    = raster_y;
  assign write_enable_b = write_enable_reg;
  assign write_data_b   = write_data_reg;
  assign frame_complete = frame_complete_reg;
  assign busy           = (state_reg != ST_IDLE);

endmodule
